// File: rtl/gate_response_checker.sv
// Self-checking monitor for the two-input gate unit (AND/OR/XOR outputs).
// Optional macro GATE_CHECKER_FIRST_FAIL_EN builds the first-failure snapshot register (err_vec).
module gate_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             y0,
  input  logic             y1,
  input  logic             y2,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [4:0]       err_vec,
  output logic [3:0]       coverage,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, WAIT} state_e;

  localparam logic [3:0]       SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [1:0]       ab_prev_q, ab_prev_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             err_q, err_d;
  logic [3:0]       cov_q, cov_d;

  logic [1:0] ab;
  logic       ab_changed;
  logic       settled;
  logic       match;

  assign ab         = {a, b};
  assign ab_changed = (ab != ab_prev_q);
  assign settled    = (settle_cnt_q == SettleLast);
  assign match      = ({y0, y1, y2} == {a & b, a | b, a ^ b});

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = SETTLE;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        SETTLE:  if (!ab_changed && settled) state_d = CHECK;
        CHECK:   state_d = WAIT;
        WAIT:    if (ab_changed) state_d = SETTLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == SETTLE) || (state_q == CHECK);
  end

  // start outranks every state action, including an input change in the same cycle
  always_comb begin
    ab_prev_d    = ab_prev_q;
    settle_cnt_d = settle_cnt_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    err_d        = err_q;
    cov_d        = cov_q;
    if (start) begin
      ab_prev_d    = ab;
      settle_cnt_d = '0;
      pass_d       = '0;
      fail_d       = '0;
      err_d        = 1'b0;
      cov_d        = '0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (ab_changed) begin
            ab_prev_d    = ab;
            settle_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + 4'd1;
          end
        end
        CHECK: begin
          if (match) begin
            if (pass_q != '1) pass_d = pass_q + CntOne;
          end else begin
            if (fail_q != '1) fail_d = fail_q + CntOne;
            err_d = 1'b1;
          end
          cov_d[ab] = 1'b1;
        end
        WAIT: begin
          if (ab_changed) begin
            ab_prev_d    = ab;
            settle_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ab_prev_q    <= '0;
      settle_cnt_q <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      err_q        <= 1'b0;
      cov_q        <= '0;
    end else begin
      ab_prev_q    <= ab_prev_d;
      settle_cnt_q <= settle_cnt_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      err_q        <= err_d;
      cov_q        <= cov_d;
    end
  end

`ifdef GATE_CHECKER_FIRST_FAIL_EN
  logic [4:0] err_vec_q, err_vec_d;

  always_comb begin
    err_vec_d = err_vec_q;
    if (start)                                        err_vec_d = '0;
    else if (state_q == CHECK && !match && !err_q)    err_vec_d = {a, b, y0, y1, y2};
  end

  always_ff @(posedge clk) begin
    if (rst) err_vec_q <= '0;
    else     err_vec_q <= err_vec_d;
  end

  assign err_vec = err_vec_q;
`else
  assign err_vec = '0;
`endif

  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign err      = err_q;
  assign coverage = cov_q;
  assign done     = (cov_q == 4'b1111);

endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Synthesizable self-checking monitor for the two-input logic-gate unit. It is the observing end of the gate unit's interface: the stimulus side drives `a`/`b`, and this block watches `a`, `b` and the three gate outputs. After each input change it waits a settle window, then compares the outputs against their expected values. It counts passes and failures, tracks which of the four input combinations have been exercised, and raises `done` once full coverage is reached. It sits beside the gate unit in the lab build and in simulation, and replaces manual waveform inspection.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles to wait after an input change before comparing. Legal range is 1 to 15.
- `CNT_W`, default 8: width of the pass and fail counters.

Ports:
- `clk`: input, 1 bit. Single clock.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `start`: input, 1 bit. One-cycle pulse that clears all results and arms the checker.
- `a`, `b`: inputs, 1 bit each. Gate-unit inputs, as driven by the stimulus side.
- `y0`, `y1`, `y2`: inputs, 1 bit each. Gate-unit outputs. Expected values:
  - `y0` = a AND b
  - `y1` = a OR b
  - `y2` = a XOR b
- `pass_cnt`: output, `CNT_W` bits. Number of passing checks; saturates.
- `fail_cnt`: output, `CNT_W` bits. Number of failing checks; saturates.
- `err`: output, 1 bit. Sticky; set on the first failing check.
- `err_vec`: output, 5 bits. Snapshot {a,b,y0,y1,y2} of the first failing check.
- `coverage`: output, 4 bits. Bit {a,b} is set once that combination has been checked.
- `done`: output, 1 bit. Equals `coverage == 4'b1111`.
- `busy`: output, 1 bit. High in SETTLE and CHECK.

## Operation
- States are IDLE, SETTLE, CHECK and WAIT. Reset enters IDLE.
- IDLE:
  - All result registers hold their values.
  - A `start` pulse clears the counters, `err`, `err_vec` and `coverage`, latches {a,b} into `ab_prev`, and loads `settle_cnt` with 0.
  - The next state is SETTLE.
- SETTLE:
  - `settle_cnt` increments each cycle.
  - If {a,b} differs from `ab_prev`, the block updates `ab_prev`, reloads `settle_cnt` to 0 and stays in SETTLE. The window restarts; no check is made.
  - When `settle_cnt == SETTLE_CYCLES-1` and the inputs are stable, the next state is CHECK.
- CHECK (one cycle):
  - Compare {y0,y1,y2} against the expected values computed from the current {a,b}.
  - A match increments `pass_cnt`. A mismatch increments `fail_cnt` and sets `err`; `err_vec` captures only if `err` was 0.
  - Set `coverage[{a,b}]`.
  - The next state is WAIT.
- WAIT:
  - If {a,b} differs from `ab_prev`, update `ab_prev`, set `settle_cnt` to 0 and go to SETTLE.
  - Otherwise stay in WAIT. A stable vector is checked exactly once.
- `start` in any state other than IDLE has the same effect as in IDLE: it clears the results and goes to SETTLE. `start` takes priority over an input change in the same cycle.
- Counters saturate at 2^CNT_W−1 and do not wrap. `err` and coverage bits still update when a counter is saturated.
- `done` stays asserted until `start` or `rst`. The checker keeps checking while `done` is high.

## Timing
- Reset values:
  - State is IDLE.
  - `pass_cnt`, `fail_cnt`, `err`, `err_vec`, `coverage`, `done`, `busy` and `ab_prev` are all 0.
- All outputs are registered. `done` is derived from the registered `coverage` with no extra cycle.
- Check latency: an input change sampled at edge k updates the counters at edge k+SETTLE_CYCLES+1. The result is visible from that edge onward. With `SETTLE_CYCLES`=2, a change at edge k produces the count at edge k+3.
- The start-to-first-check latency follows the same rule, counted from the `start` edge.
- An input change on the edge where the state is CHECK is not seen by that check. It is detected in WAIT on the next edge and triggers a new window.
- `rst` asserted mid-operation returns the block to IDLE at the next edge and clears everything. There is no partial-update hazard.

## Configuration
- `GATE_CHECKER_FIRST_FAIL_EN`
- When defined: the `err_vec` capture register is built and behaves as described above.
- When undefined: `err_vec` is tied to 5'b00000 and the capture logic is removed. `err`, the counters and the coverage logic are unchanged.

## Test plan
- Default parameters. Reset, pulse `start`, then drive 00, 01, 10 and 11 with correct gate outputs, each vector held for 10 cycles. Expected result: `pass_cnt`=4, `fail_cnt`=0, `err`=0, `coverage`=1111, `done`=1.
- Drive a=1, b=1 with y2 forced to 1. Expected result: `fail_cnt`=1, `err`=1, `err_vec`=5'b11111. A second fault on 01 with y1=0 gives `fail_cnt`=2 and leaves `err_vec` unchanged.
- Toggle b every cycle for 6 cycles, then hold. Expected result: exactly one check, occurring SETTLE_CYCLES+1 edges after the last change, so `pass_cnt`=1.
- `CNT_W`=2. Run 5 passing checks by alternating 00 and 01. Expected result: `pass_cnt` saturates at 3.
- Assert `rst` during SETTLE after 2 passes. Expected result: all outputs are 0 on the next edge and the state is IDLE. A later `start` resumes checking from 0.
- Build without `GATE_CHECKER_FIRST_FAIL_EN` and inject a failure. Expected result: `err`=1 and `err_vec`=0.
